// File: rtl/exec_pkg.sv
// Shared widths, opcode encodings and FSM state encoding for the execute stage.
package exec_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 4;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_MOVB = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    // Every encoding above MUL is a no-op: no write-back, flags untouched.
    function automatic logic is_nop(input logic [3:0] op);
        return op > OP_MUL;
    endfunction

endpackage

// File: rtl/exec_if.sv
// Decoder-to-execute bundle: op/operand handshake in, write-back triple and flags out.
interface exec_if
    import exec_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_AW,
    parameter int OW = OP_W
);
    // Handshake: an op transfers on a rising edge where in_valid && in_ready;
    // upstream holds opcode/operands/dst_reg/wr_en stable until that edge.
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] opcode;
    logic [DW-1:0] Dout1;
    logic [DW-1:0] Dout2;
    logic [AW-1:0] dst_reg;
    logic          wr_en;

    logic          RegWrite_Flag;
    logic [AW-1:0] Wreg;
    logic [DW-1:0] Datain;
    logic          zero_flag;
    logic          ovf_flag;

    modport slave (
        input  in_valid, opcode, Dout1, Dout2, dst_reg, wr_en,
        output in_ready, RegWrite_Flag, Wreg, Datain, zero_flag, ovf_flag
    );

    modport master (
        output in_valid, opcode, Dout1, Dout2, dst_reg, wr_en,
        input  in_ready, RegWrite_Flag, Wreg, Datain, zero_flag, ovf_flag
    );

endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one partial product per cycle, W cycles per product.
module seq_multiplier #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] mcand_q, mcand_d;
    logic [2*W-1:0] acc_q,   acc_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic           busy_q,  busy_d;
    logic [2*W-1:0] acc_sum;

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            mcand_d  = {{W{1'b0}}, a_i};
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    // The last iteration's sum is the product, so it is valid while done_o is high.
    assign busy_o    = busy_q;
    assign done_o    = busy_q && (cnt_q == LAST);
    assign product_o = acc_sum;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus sequential multiply, producing the register-file write-back.
module execute_stage
    import exec_pkg::*;
#(
    parameter int DATA_W = exec_pkg::DATA_W,
    parameter int REG_AW = exec_pkg::REG_AW,
    parameter int OP_W   = exec_pkg::OP_W
) (
    input  logic       clk,
    input  logic       rst_n,
    exec_if.slave      bus,
    output logic [0:0] state_o
);

    localparam int SH_W = $clog2(DATA_W);

    logic [0:0]        state_q, state_d;
    logic              ready_q, ready_d;
    logic              rwf_q,   rwf_d;
    logic [REG_AW-1:0] wreg_q,  wreg_d;
    logic [DATA_W-1:0] din_q,   din_d;
    logic              zero_q,  zero_d;
    logic              ovf_q,   ovf_d;
    logic [REG_AW-1:0] dst_q,   dst_d;
    logic              wen_q,   wen_d;

    logic [DATA_W-1:0]   alu_res;
    logic                alu_ovf;
    logic                accept;
    logic                mul_start;
    logic                mul_busy;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign accept    = bus.in_valid && ready_q;
    assign mul_start = accept && (bus.opcode == OP_MUL);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.opcode)
            OP_ADD:  {alu_ovf, alu_res} = {1'b0, bus.Dout1} + {1'b0, bus.Dout2};
            OP_SUB:  {alu_ovf, alu_res} = {1'b0, bus.Dout1} - {1'b0, bus.Dout2};
            OP_AND:  alu_res = bus.Dout1 & bus.Dout2;
            OP_OR:   alu_res = bus.Dout1 | bus.Dout2;
            OP_XOR:  alu_res = bus.Dout1 ^ bus.Dout2;
            OP_SLL:  alu_res = bus.Dout1 << bus.Dout2[SH_W-1:0];
            OP_SRL:  alu_res = bus.Dout1 >> bus.Dout2[SH_W-1:0];
            OP_MOVB: alu_res = bus.Dout2;
            default: ;
        endcase
    end

    seq_multiplier #(.W(DATA_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .a_i       (bus.Dout1),
        .b_i       (bus.Dout2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        rwf_d   = 1'b0;
        wreg_d  = wreg_q;
        din_d   = din_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dst_d   = dst_q;
        wen_d   = wen_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (mul_start) begin
                    state_d = S_MUL;
                    ready_d = 1'b0;
                    dst_d   = bus.dst_reg;
                    wen_d   = bus.wr_en;
                end else if (accept && !is_nop(bus.opcode)) begin
                    rwf_d  = bus.wr_en;
                    wreg_d = bus.dst_reg;
                    din_d  = alu_res;
                    zero_d = (alu_res == '0);
                    ovf_d  = alu_ovf;
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    rwf_d   = wen_q;
                    wreg_d  = dst_q;
                    din_d   = mul_product[DATA_W-1:0];
                    zero_d  = (mul_product[DATA_W-1:0] == '0);
                    ovf_d   = |mul_product[2*DATA_W-1:DATA_W];
                end else if (!mul_busy) begin
                    // Multiplier idle without finishing: drop the op rather than stall forever.
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rwf_q   <= 1'b0;
            wreg_q  <= '0;
            din_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dst_q   <= '0;
            wen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rwf_q   <= rwf_d;
            wreg_q  <= wreg_d;
            din_q   <= din_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dst_q   <= dst_d;
            wen_q   <= wen_d;
        end
    end

    assign bus.in_ready      = ready_q;
    assign bus.RegWrite_Flag = rwf_q;
    assign bus.Wreg          = wreg_q;
    assign bus.Datain        = din_q;
    assign bus.zero_flag     = zero_q;
    assign bus.ovf_flag      = ovf_q;
    assign state_o           = state_q;

endmodule
